addsub_seq: RTL
===============

# addsub_seq

Multi-cycle, byte-serial add/subtract unit that time-multiplexes one `add8` across an N-byte operand. It runs low byte first, carrying between bytes through a flip-flop, and delivers the full-width result with flags. It sits directly downstream of the 8-bit adder, as the first sequential arithmetic stage on the path toward the CPU datapath. Each wide add then costs one adder instance plus registers, instead of N chained adders.

## Interface

- `NBYTES`, default 2: operand width in bytes; W = 8*NBYTES; legal range 1..8.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `sub` input 1: 0 = add (a+b+carry_in), 1 = subtract (a−b).
- `a` input W: operand A; captured on accept.
- `b` input W: operand B; captured on accept.
- `carry_in` input 1: initial carry for add; ignored when `sub`=1. Captured on accept.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: one-cycle pulse when result/flags update.
- `result` output W: registered sum or difference.
- `carry_out` output 1: carry from the top byte; for subtract, 1 = no borrow.
- `overflow` output 1: signed two's-complement overflow.
- `zero` output 1: result == 0 across the full width.

## Operation

- States: IDLE, RUN, DONE (enum in package).
- IDLE:
  - `start`=1 captures `a`, `b`, `sub` and `carry_in`.
  - Stored B is `sub ? ~b : b`.
  - Carry flop is set to `sub ? 1 : carry_in`.
  - Byte index k is set to 0, and the state moves to RUN.
- RUN:
  - `add8` inputs are A[8k+7:8k], B'[8k+7:8k] and the carry flop.
  - At the edge, the byte sum goes into the internal accumulator slice k, the carry flop takes `add8` carry_out, and k increments.
  - When k == NBYTES−1, the next state is DONE.
- DONE:
  - The full accumulator is copied to `result` together with the flags.
  - `done`=1 for this cycle only.
  - The next state is IDLE.
- Output registers change only on entry to DONE. Partial byte results are never visible on `result`.
- Flags (computed from captured operands and the final sum):
  - `carry_out` = final carry flop.
  - `overflow` = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]).
  - `zero` = ~|sum.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1.
- `start` in RUN or DONE is ignored, not queued. The requester holds or re-issues `start` until it sees IDLE (`busy`=0).
- Reset:
  - Asynchronous, any state.
  - State goes to IDLE; k, the carry flop, the accumulator, captured operands, `result`, `carry_out`, `overflow`, `zero`, `done` and `busy` all go to 0.
  - An interrupted operation produces no `done` and no partial result.

## Timing

- Accept edge: `start`=1 in IDLE at edge E0.
- RUN occupies cycles E0..E(NBYTES). `done`=1 and the new `result` and flags are visible in the cycle after edge E(NBYTES).
- Latency from accept to `done`: NBYTES+1 cycles (3 for NBYTES=2).
- Throughput: one operation per NBYTES+2 cycles. The earliest next accept is the IDLE cycle following DONE.
- `busy` rises in the cycle after the accept edge. It falls in the cycle after DONE.
- `result` and flags hold until the next DONE or reset.
- The carry path is one `add8` per cycle. There is no combinational path from `start` or operands to outputs.

## Structure

- Package `addsub_seq_pkg`:
  - state enum (IDLE, RUN, DONE);
  - `BYTE_W`=8 constant;
  - byte-index width function clog2(NBYTES) (minimum 1).
- One sub-module instance: the existing `add8` (single instance, shared across bytes).
- Everything else lives in this module: FSM, byte counter, carry flop, accumulator, output registers.

## Test plan

All scenarios use NBYTES=2.

- **Carry across bytes:** add 0x00FF+0x0001, carry_in=0 → result 0x0100, carry_out 0, zero 0, overflow 0. `done` in the 3rd cycle after accept, for exactly one cycle.
- **Wrap-around:** add 0xFFFF+0x0001 → result 0x0000, carry_out 1, zero 1, overflow 0. A second case adds 0x0001+0x0001 with carry_in=1 → 0x0003.
- **Subtract:**
  - 0x1000−0x0001 → 0x0FFF, carry_out 1.
  - 0x0000−0x0001 → 0xFFFF, carry_out 0, overflow 0. carry_in=1 in this case must be ignored.
- **Signed overflow:**
  - add 0x7FFF+0x0001 → 0x8000, overflow 1.
  - sub 0x8000−0x0001 → 0x7FFF, overflow 1.
- **Handshake:**
  - Pulse `start` in RUN and DONE with different operands: ignored; `busy` stays 1.
  - `result` is unchanged until DONE.
  - A new accept in the first IDLE cycle after DONE succeeds.
- **Reset mid-operation:**
  - Assert `rst` in the second RUN cycle: all outputs go 0 immediately (asynchronously), and no `done` follows.
  - After release, a fresh add 0x1234+0x1111 → 0x2345.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the byte-serial add/subtract unit.
package addsub_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the byte index: clog2(nbytes), never less than one bit.
    function automatic int idx_w(input int nbytes);
        int w;
        if (nbytes <= 1) begin
            w = 1;
        end else begin
            w = $clog2(nbytes);
        end
        return w;
    endfunction

endpackage

// File: rtl/add8.sv
// 8-bit ripple adder with carry in/out; purely combinational.
module add8
    import addsub_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq.sv
// Byte-serial add/subtract: one shared add8 walks the operands low byte
// first, carrying through a flop; result and flags update only on entry
// to DONE so partial sums never reach the outputs.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     carry_in,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     carry_out,
    output logic                     overflow,
    output logic                     zero
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int KW = idx_w(NBYTES);
    localparam logic [KW-1:0] LAST_K = KW'(NBYTES - 1);

    state_t          state_r;
    logic [KW-1:0]   k_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;     // already inverted for subtract
    logic [W-1:0]    acc_r;
    logic [W-1:0]    acc_next_s;
    logic [BYTE_W-1:0] sum_s;
    logic            cout_s;

    add8 u_add8 (
        .a    (a_r[k_r*BYTE_W +: BYTE_W]),
        .b    (b_r[k_r*BYTE_W +: BYTE_W]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Accumulator with the current byte slice replaced by this cycle's sum.
    always_comb begin
        acc_next_s = acc_r;
        acc_next_s[k_r*BYTE_W +: BYTE_W] = sum_s;
    end

    // Control FSM, byte datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            k_r       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : carry_in;
                        k_r     <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_next_s;
                    carry_r <= cout_s;
                    if (k_r == LAST_K) begin
                        result    <= acc_next_s;
                        carry_out <= cout_s;
                        overflow  <= (a_r[W-1] == b_r[W-1]) &&
                                     (acc_next_s[W-1] != a_r[W-1]);
                        zero      <= ~|acc_next_s;
                        done      <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        k_r     <= k_r + KW'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
